// File: rtl/pw_trigger_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pw_trigger_capture_ctrl
//
// Front-end capture sequencer for the PhyWhisperer sniff path.
//   * Arms on a rising edge of the host arm level.
//   * Waits for a single-cycle pattern-match pulse.
//   * Emits a trigger pulse after a programmed delay, for a programmed width.
//   * In parallel, gates sniff-FIFO writes for a programmed number of
//     capture strobes, flags a sticky overflow and reports DONE.
//
// Ports
//   fe_clk           sole clock
//   reset_i          synchronous reset, active-high
//   I_arm            arm level (already in fe_clk domain)
//   I_match          1-cycle pattern-match pulse
//   I_trigger_delay  match-to-trigger delay, fe_clk cycles
//   I_trigger_width  trigger high time, fe_clk cycles (0 behaves as 1)
//   I_capture_len    capture strobes to accept (0 = unlimited)
//   I_capture_wr     front-end capture strobe
//   I_fifo_full      sniff FIFO full (write side)
//   O_capture_en     FIFO write gate
//   O_trigger        registered trigger output
//   O_match_disarm   1-cycle pulse when a match is accepted
//   O_armed          high while waiting for a match
//   O_done           high once trigger and capture are both finished
//   O_overflow       sticky: strobe offered while capturing with FIFO full
//   O_state          current state encoding for status readback
//
// Every output comes straight from a flop, so the trigger pin and the FIFO
// gate are glitch-free and change on the same edge as O_state.
// ---------------------------------------------------------------------------
module pw_trigger_capture_ctrl #(
  parameter int pTRIGGER_DELAY_WIDTH = 20,
  parameter int pTRIGGER_WIDTH_WIDTH = 16,
  parameter int pCAPTURE_LEN_WIDTH   = 16
) (
  input  logic                            fe_clk,
  input  logic                            reset_i,
  input  logic                            I_arm,
  input  logic                            I_match,
  input  logic [pTRIGGER_DELAY_WIDTH-1:0] I_trigger_delay,
  input  logic [pTRIGGER_WIDTH_WIDTH-1:0] I_trigger_width,
  input  logic [pCAPTURE_LEN_WIDTH-1:0]   I_capture_len,
  input  logic                            I_capture_wr,
  input  logic                            I_fifo_full,
  output logic                            O_capture_en,
  output logic                            O_trigger,
  output logic                            O_match_disarm,
  output logic                            O_armed,
  output logic                            O_done,
  output logic                            O_overflow,
  output logic [2:0]                      O_state
);

  localparam int DW = pTRIGGER_DELAY_WIDTH;
  localparam int WW = pTRIGGER_WIDTH_WIDTH;
  localparam int LW = pCAPTURE_LEN_WIDTH;

  localparam logic [DW-1:0] DELAY_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] WIDTH_ONE = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] COUNT_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] COUNT_MAX = {LW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DELAY    = 3'd2,
    ST_PULSE    = 3'd3,
    ST_WAIT_CAP = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t          state_reg;
  logic            arm_prev_reg;
  logic [DW-1:0]   delay_cnt_reg;
  logic [WW-1:0]   width_cnt_reg;
  logic [WW-1:0]   width_reg;
  logic [LW-1:0]   len_reg;
  logic [LW-1:0]   count_reg;
  logic            capture_en_reg;
  logic            trigger_reg;
  logic            match_disarm_reg;
  logic            armed_reg;
  logic            done_reg;
  logic            overflow_reg;

  logic            capture_hit;
  logic [LW-1:0]   count_next;
  logic            cap_complete_next;

  // The width counter runs from width-1 down to 0, so the pulse is high for
  // exactly "width" cycles; a programmed width of 0 collapses to a single
  // cycle rather than wrapping to a huge pulse.
  function automatic logic [WW-1:0] width_to_count(input logic [WW-1:0] w);
    if (w == '0) begin
      return '0;
    end else begin
      return w - WIDTH_ONE;
    end
  endfunction

  // Strobe accounting. The count includes strobes the FIFO drops while full,
  // so the capture window length does not depend on FIFO back-pressure.
  // "Complete" is evaluated against the post-edge count so that the write
  // gate closes on the same edge that accepts the final strobe.
  always_comb begin
    capture_hit = capture_en_reg & I_capture_wr;
    count_next  = count_reg;
    if (capture_hit && (count_reg != COUNT_MAX)) begin
      count_next = count_reg + COUNT_ONE;
    end
    cap_complete_next = (len_reg != '0) && (count_next >= len_reg);
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_reg        <= ST_IDLE;
      arm_prev_reg     <= 1'b0;
      delay_cnt_reg    <= '0;
      width_cnt_reg    <= '0;
      width_reg        <= '0;
      len_reg          <= '0;
      count_reg        <= '0;
      capture_en_reg   <= 1'b0;
      trigger_reg      <= 1'b0;
      match_disarm_reg <= 1'b0;
      armed_reg        <= 1'b0;
      done_reg         <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      arm_prev_reg     <= I_arm;
      match_disarm_reg <= 1'b0;
      count_reg        <= count_next;

      // Sticky until the next arm; kept through abort for readback.
      if (capture_hit && I_fifo_full) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          // Only a fresh edge arms; a level held high after DONE does not.
          if (I_arm && !arm_prev_reg) begin
            state_reg    <= ST_ARMED;
            armed_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            count_reg    <= '0;
          end
        end

        ST_ARMED: begin
          // Abort takes priority over a coincident match.
          if (!I_arm) begin
            state_reg <= ST_IDLE;
            armed_reg <= 1'b0;
          end else if (I_match) begin
            armed_reg        <= 1'b0;
            match_disarm_reg <= 1'b1;
            capture_en_reg   <= 1'b1;
            width_reg        <= I_trigger_width;
            len_reg          <= I_capture_len;
            if (I_trigger_delay != '0) begin
              // Counter reaches 0 after "delay" cycles in DELAY.
              state_reg     <= ST_DELAY;
              delay_cnt_reg <= I_trigger_delay - DELAY_ONE;
            end else begin
              state_reg     <= ST_PULSE;
              trigger_reg   <= 1'b1;
              width_cnt_reg <= width_to_count(I_trigger_width);
            end
          end
        end

        ST_DELAY: begin
          if (!I_arm) begin
            state_reg      <= ST_IDLE;
            trigger_reg    <= 1'b0;
            capture_en_reg <= 1'b0;
          end else begin
            capture_en_reg <= ~cap_complete_next;
            if (delay_cnt_reg == '0) begin
              state_reg     <= ST_PULSE;
              trigger_reg   <= 1'b1;
              width_cnt_reg <= width_to_count(width_reg);
            end else begin
              delay_cnt_reg <= delay_cnt_reg - DELAY_ONE;
            end
          end
        end

        ST_PULSE: begin
          if (!I_arm) begin
            state_reg      <= ST_IDLE;
            trigger_reg    <= 1'b0;
            capture_en_reg <= 1'b0;
          end else begin
            capture_en_reg <= ~cap_complete_next;
            if (width_cnt_reg == '0) begin
              trigger_reg <= 1'b0;
              if (cap_complete_next) begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= ST_WAIT_CAP;
              end
            end else begin
              width_cnt_reg <= width_cnt_reg - WIDTH_ONE;
            end
          end
        end

        ST_WAIT_CAP: begin
          if (!I_arm) begin
            state_reg      <= ST_IDLE;
            capture_en_reg <= 1'b0;
          end else if (cap_complete_next) begin
            state_reg      <= ST_DONE;
            done_reg       <= 1'b1;
            capture_en_reg <= 1'b0;
          end
        end

        ST_DONE: begin
          capture_en_reg <= 1'b0;
          if (!I_arm) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          trigger_reg    <= 1'b0;
          capture_en_reg <= 1'b0;
          armed_reg      <= 1'b0;
          done_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign O_capture_en   = capture_en_reg;
  assign O_trigger      = trigger_reg;
  assign O_match_disarm = match_disarm_reg;
  assign O_armed        = armed_reg;
  assign O_done         = done_reg;
  assign O_overflow     = overflow_reg;
  assign O_state        = state_reg;

endmodule

// File: tb/tb_pw_trigger_capture_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for pw_trigger_capture_ctrl: a table of cycle vectors from reset, a
// set of directed multi-cycle scenarios, and a randomized run, all checked
// every cycle against a reference model that derives trigger timing from the
// match time with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_pw_trigger_capture_ctrl;

  localparam int DW = 20;
  localparam int WW = 16;
  localparam int LW = 16;

  localparam int S_IDLE = 0, S_ARMED = 1, S_DELAY = 2, S_PULSE = 3, S_WAIT = 4, S_DONE = 5;

  logic          fe_clk = 1'b0;
  logic          reset_i;
  logic          arm, match, wr, full;
  logic [DW-1:0] dly;
  logic [WW-1:0] wid;
  logic [LW-1:0] len;
  logic          O_capture_en, O_trigger, O_match_disarm, O_armed, O_done, O_overflow;
  logic [2:0]    O_state;

  always #5 fe_clk = ~fe_clk;

  pw_trigger_capture_ctrl #(
    .pTRIGGER_DELAY_WIDTH(DW),
    .pTRIGGER_WIDTH_WIDTH(WW),
    .pCAPTURE_LEN_WIDTH  (LW)
  ) dut (
    .fe_clk         (fe_clk),
    .reset_i        (reset_i),
    .I_arm          (arm),
    .I_match        (match),
    .I_trigger_delay(dly),
    .I_trigger_width(wid),
    .I_capture_len  (len),
    .I_capture_wr   (wr),
    .I_fifo_full    (full),
    .O_capture_en   (O_capture_en),
    .O_trigger      (O_trigger),
    .O_match_disarm (O_match_disarm),
    .O_armed        (O_armed),
    .O_done         (O_done),
    .O_overflow     (O_overflow),
    .O_state        (O_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Trackers fed from DUT outputs, compared against bench-computed values.
  int trig_hi, dis_cnt, first_rise, mc;

  // Reference model state.
  int m_state, m_mt, m_d, m_w, m_len, m_cnt;
  bit m_prev;
  bit e_trig, e_en, e_dis, e_armed, e_done, e_ovf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_mt = 0; m_d = 0; m_w = 1; m_len = 0; m_cnt = 0; m_prev = 0;
    e_trig = 0; e_en = 0; e_dis = 0; e_armed = 0; e_done = 0; e_ovf = 0;
  endtask

  // Advance the model across edge t; results are the outputs of cycle t+1.
  task automatic model_step(input int t);
    bit counted, complete;
    int rise, fall;
    e_dis   = 0;
    counted = e_en && wr;
    if (counted && m_cnt < 65535) m_cnt++;
    if (counted && full) e_ovf = 1;
    complete = (m_len != 0) && (m_cnt >= m_len);
    case (m_state)
      S_IDLE: if (arm && !m_prev) begin m_state = S_ARMED; e_ovf = 0; m_cnt = 0; end
      S_ARMED: begin
        if (!arm) m_state = S_IDLE;
        else if (match) begin
          m_mt = t; m_d = int'(dly); m_w = (wid == 0) ? 1 : int'(wid); m_len = int'(len);
          e_dis = 1; e_en = 1; m_state = S_DELAY;
        end
      end
      S_DELAY, S_PULSE: if (!arm) begin m_state = S_IDLE; e_en = 0; end
      S_WAIT: begin
        if (!arm) begin m_state = S_IDLE; e_en = 0; end
        else if (complete) begin m_state = S_DONE; e_en = 0; end
      end
      S_DONE: begin e_en = 0; if (!arm) m_state = S_IDLE; end
      default: m_state = S_IDLE;
    endcase
    e_trig = 0;
    if (m_state == S_DELAY || m_state == S_PULSE) begin
      rise = m_mt + 1 + m_d;
      fall = rise + m_w;
      if (!e_dis) e_en = !complete;
      if (t + 1 < rise) m_state = S_DELAY;
      else if (t + 1 < fall) begin m_state = S_PULSE; e_trig = 1; end
      else m_state = complete ? S_DONE : S_WAIT;
    end
    e_armed = (m_state == S_ARMED);
    e_done  = (m_state == S_DONE);
    m_prev  = arm;
  endtask

  task automatic tick();
    @(posedge fe_clk);
    if (reset_i) model_reset();
    else model_step(cyc);
    #1;
    chk("trigger",    int'(O_trigger),      int'(e_trig));
    chk("capture_en", int'(O_capture_en),   int'(e_en));
    chk("disarm",     int'(O_match_disarm), int'(e_dis));
    chk("armed",      int'(O_armed),        int'(e_armed));
    chk("done",       int'(O_done),         int'(e_done));
    chk("overflow",   int'(O_overflow),     int'(e_ovf));
    chk("state",      int'(O_state),        m_state);
    if (O_trigger) begin
      trig_hi++;
      if (first_rise < 0) first_rise = cyc + 1;
    end
    if (O_match_disarm) dis_cnt++;
    cyc++;
  endtask

  task automatic clr_track();
    trig_hi = 0; dis_cnt = 0; first_rise = -1;
  endtask

  task automatic set_in(input logic a, input logic m, input logic w, input logic f);
    arm = a; match = m; wr = w; full = f;
  endtask

  task automatic set_cfg(input int d, input int w, input int l);
    dly = DW'(d); wid = WW'(w); len = LW'(l);
  endtask

  typedef struct {
    logic a, m, w, f;
    int   d, wd, l;
    logic t, en, ds, ar, dn, ov;
    int   st;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(input logic a, input logic m, input logic w, input logic f,
                              input int d, input int wd, input int l,
                              input logic t, input logic en, input logic ds, input logic ar,
                              input logic dn, input logic ov, input int st);
    vec_t v;
    v.a = a; v.m = m; v.w = w; v.f = f; v.d = d; v.wd = wd; v.l = l;
    v.t = t; v.en = en; v.ds = ds; v.ar = ar; v.dn = dn; v.ov = ov; v.st = st;
    return v;
  endfunction

  initial begin
    // Cycle vectors from reset: arm, match with delay 0 / width 1 / len 4,
    // overflow on a full strobe, DONE held, re-arm clears overflow, then a
    // delay-2 match and an abort from WAIT_CAP.
    //            a  m  w  f  d  wd l   trg en dis arm dn ovf st
    tv[0]  = mk(0, 0, 0, 0, 0, 1, 4,  0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 1, 4,  0, 0, 0, 1, 0, 0, 1);
    tv[2]  = mk(1, 0, 1, 0, 0, 1, 4,  0, 0, 0, 1, 0, 0, 1);
    tv[3]  = mk(1, 1, 0, 0, 0, 1, 4,  1, 1, 1, 0, 0, 0, 3);
    tv[4]  = mk(1, 0, 1, 0, 0, 1, 4,  0, 1, 0, 0, 0, 0, 4);
    tv[5]  = mk(1, 0, 1, 1, 0, 1, 4,  0, 1, 0, 0, 0, 1, 4);
    tv[6]  = mk(1, 0, 0, 0, 0, 1, 4,  0, 1, 0, 0, 0, 1, 4);
    tv[7]  = mk(1, 0, 1, 0, 0, 1, 4,  0, 1, 0, 0, 0, 1, 4);
    tv[8]  = mk(1, 0, 1, 0, 0, 1, 4,  0, 0, 0, 0, 1, 1, 5);
    tv[9]  = mk(1, 0, 1, 0, 0, 1, 4,  0, 0, 0, 0, 1, 1, 5);
    tv[10] = mk(0, 0, 0, 0, 0, 1, 4,  0, 0, 0, 0, 0, 1, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 1, 4,  0, 0, 0, 0, 0, 1, 0);
    tv[12] = mk(1, 0, 0, 0, 2, 1, 4,  0, 0, 0, 1, 0, 0, 1);
    tv[13] = mk(1, 1, 0, 0, 2, 1, 4,  0, 1, 1, 0, 0, 0, 2);
    tv[14] = mk(1, 0, 0, 0, 2, 1, 4,  0, 1, 0, 0, 0, 0, 2);
    tv[15] = mk(1, 0, 0, 0, 2, 1, 4,  1, 1, 0, 0, 0, 0, 3);
    tv[16] = mk(1, 0, 0, 0, 2, 1, 4,  0, 1, 0, 0, 0, 0, 4);
    tv[17] = mk(0, 0, 0, 0, 2, 1, 4,  0, 0, 0, 0, 0, 0, 0);

    clr_track();
    reset_i = 1'b1;
    set_in(0, 0, 0, 0);
    set_cfg(0, 1, 4);
    repeat (3) tick();
    reset_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      set_in(tv[i].a, tv[i].m, tv[i].w, tv[i].f);
      set_cfg(tv[i].d, tv[i].wd, tv[i].l);
      tick();
      chk("tv_trigger",  int'(O_trigger),      int'(tv[i].t));
      chk("tv_cap_en",   int'(O_capture_en),   int'(tv[i].en));
      chk("tv_disarm",   int'(O_match_disarm), int'(tv[i].ds));
      chk("tv_armed",    int'(O_armed),        int'(tv[i].ar));
      chk("tv_done",     int'(O_done),         int'(tv[i].dn));
      chk("tv_overflow", int'(O_overflow),     int'(tv[i].ov));
      chk("tv_state",    int'(O_state),        tv[i].st);
      $display("vec %0d: arm=%0b match=%0b wr=%0b full=%0b -> state=%0d trig=%0b en=%0b",
               i, tv[i].a, tv[i].m, tv[i].w, tv[i].f, O_state, O_trigger, O_capture_en);
    end

    // Delay 10, width 5: trigger on cycles N+11..N+15, one disarm pulse.
    set_cfg(10, 5, 0);
    set_in(1, 0, 0, 0); tick();
    clr_track();
    mc = cyc;
    set_in(1, 1, 0, 0); tick();
    set_in(1, 0, 0, 0);
    repeat (25) tick();
    chk("t2_rise_cycle", first_rise, mc + 11);
    chk("t2_width", trig_hi, 5);
    chk("t2_disarm_pulses", dis_cnt, 1);
    $display("t2: delay=10 width=5 rise_offset=%0d high=%0d", first_rise - mc, trig_hi);
    set_in(0, 0, 0, 0); repeat (2) tick();

    // len 3 with the FIFO full on the second strobe; re-arm clears overflow.
    set_cfg(0, 2, 3);
    set_in(1, 0, 0, 0); tick();
    set_in(1, 1, 0, 0); tick();
    set_in(1, 0, 1, 0); tick();
    set_in(1, 0, 1, 1); tick();
    set_in(1, 0, 0, 0); tick();
    set_in(1, 0, 1, 0); tick();
    set_in(1, 0, 0, 0); tick();
    chk("t3_overflow", int'(O_overflow), 1);
    chk("t3_done", int'(O_done), 1);
    chk("t3_cap_en", int'(O_capture_en), 0);
    set_in(0, 0, 0, 0); tick();
    set_in(1, 0, 0, 0); tick();
    chk("t3_rearm_ovf_clear", int'(O_overflow), 0);
    chk("t3_rearm_state", int'(O_state), S_ARMED);
    $display("t3: len=3 full on strobe 2, overflow cleared on re-arm");
    set_in(0, 0, 0, 0); tick();

    // Abort during a long delay: trigger never fires.
    set_cfg(1000, 3, 5);
    set_in(1, 0, 0, 0); tick();
    clr_track();
    set_in(1, 1, 0, 0); tick();
    set_in(1, 0, 1, 0); repeat (50) tick();
    set_in(0, 0, 0, 0); tick();
    chk("t4_abort_state", int'(O_state), S_IDLE);
    chk("t4_abort_en", int'(O_capture_en), 0);
    repeat (1100) tick();
    chk("t4_trigger_never", trig_hi, 0);
    $display("t4: abort in DELAY, trigger cycles=%0d", trig_hi);

    // Arm held through DONE, second match in PULSE ignored.
    set_cfg(0, 20, 2);
    set_in(1, 0, 0, 0); tick();
    clr_track();
    set_in(1, 1, 0, 0); tick();
    set_in(1, 0, 1, 0); tick();
    set_in(1, 1, 1, 0); tick();
    set_in(1, 0, 0, 0); repeat (25) tick();
    chk("t5_done_state", int'(O_state), S_DONE);
    chk("t5_trigger_width", trig_hi, 20);
    chk("t5_disarm_pulses", dis_cnt, 1);
    set_in(0, 0, 0, 0); tick();
    chk("t5_idle", int'(O_state), S_IDLE);
    set_in(1, 0, 0, 0); tick();
    chk("t5_rearmed", int'(O_armed), 1);
    $display("t5: held arm through DONE, re-armed after low/high");
    set_in(0, 0, 0, 0); tick();

    // Unlimited capture, width 0 gives a single-cycle trigger.
    set_cfg(0, 0, 0);
    set_in(1, 0, 0, 0); tick();
    clr_track();
    set_in(1, 1, 0, 0); tick();
    set_in(1, 0, 1, 0); repeat (1000) tick();
    chk("t6_cap_en", int'(O_capture_en), 1);
    chk("t6_state", int'(O_state), S_WAIT);
    chk("t6_trigger_width", trig_hi, 1);
    set_in(0, 0, 0, 0); tick();
    chk("t6_abort_en", int'(O_capture_en), 0);
    $display("t6: len=0 width=0, 1000 strobes, trigger cycles=%0d", trig_hi);

    // Reset in the middle of a pulse.
    set_cfg(0, 50, 0);
    set_in(1, 0, 0, 0); tick();
    set_in(1, 1, 0, 0); tick();
    set_in(1, 0, 1, 0); repeat (3) tick();
    reset_i = 1'b1; tick();
    chk("t7_reset_trigger", int'(O_trigger), 0);
    chk("t7_reset_state", int'(O_state), S_IDLE);
    set_in(0, 0, 0, 0); reset_i = 1'b0; tick();
    $display("t7: reset during PULSE");

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 3) arm = ~arm;
      match   = ($urandom_range(99) < 6);
      wr      = ($urandom_range(1) == 1);
      full    = ($urandom_range(99) < 20);
      reset_i = ($urandom_range(999) < 3);
      set_cfg(int'($urandom_range(20)), int'($urandom_range(8)), int'($urandom_range(12)));
      tick();
      if (O_match_disarm)
        $display("rand match at cyc %0d: delay=%0d width=%0d len=%0d", cyc - 1, m_d, m_w, m_len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
